// File: rtl/msp430_trace_fifo.sv
// ---------------------------------------------------------------------------
// msp430_trace_fifo
//
// Execution-trace capture buffer for the MSP430 verification environment.
// Every dbg_clk edge it samples the core's observability strobes and records
// at most one tagged, timestamped entry (decode, IRQ or NMI) into a circular
// buffer. A monitor drains the buffer through a first-word-fall-through
// valid/ready port.
//
// Ports:
//   dbg_clk, dbg_rst      clock, synchronous active-high reset
//   en, cap_mask[2:0]     capture enable; per-event enables {nmi, irq, decode}
//   wrap                  full policy: 1 = overwrite oldest, 0 = drop newest
//   clr                   synchronous flush of contents and drop accounting
//   decode, pc, ir        instruction decode strobe with its pc / ir
//   irq_detect, irq_num   maskable IRQ taken and its vector number
//   nmi_detect            NMI taken
//   rd_valid, rd_ready    read handshake; pop when both are high
//   rd_type               01 decode, 10 irq, 11 nmi
//   rd_pc, rd_ir          captured pc / ir
//   rd_irq_num            captured irq_num (0 for decode and NMI entries)
//   rd_ts                 timestamp of the capture cycle
//   count                 occupancy
//   overflow              sticky lost-event flag
//   drop_cnt              saturating count of lost events
// ---------------------------------------------------------------------------
module msp430_trace_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 16,
    parameter int TSW   = 16,
    parameter int IRQW  = 6
) (
    input  logic                       dbg_clk,
    input  logic                       dbg_rst,
    input  logic                       en,
    input  logic [2:0]                 cap_mask,
    input  logic                       wrap,
    input  logic                       clr,
    input  logic                       decode,
    input  logic [DW-1:0]              pc,
    input  logic [DW-1:0]              ir,
    input  logic                       irq_detect,
    input  logic                       nmi_detect,
    input  logic [IRQW-1:0]            irq_num,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [1:0]                 rd_type,
    output logic [DW-1:0]              rd_pc,
    output logic [DW-1:0]              rd_ir,
    output logic [IRQW-1:0]            rd_irq_num,
    output logic [TSW-1:0]             rd_ts,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [7:0]                 drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] TYPE_DECODE = 2'b01;
    localparam logic [1:0] TYPE_IRQ    = 2'b10;
    localparam logic [1:0] TYPE_NMI    = 2'b11;

    // Entry storage, one array per field
    logic [1:0]      mem_type   [DEPTH];
    logic [DW-1:0]   mem_pc     [DEPTH];
    logic [DW-1:0]   mem_ir     [DEPTH];
    logic [IRQW-1:0] mem_irq    [DEPTH];
    logic [TSW-1:0]  mem_ts     [DEPTH];

    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [TSW-1:0]  ts;

    logic            nmi_q;
    logic            irq_q;
    logic            dec_q;
    logic            push;
    logic            full;
    logic            pop;
    logic            write;
    logic            lost_full;
    logic [1:0]      n_qual;
    logic [1:0]      losers;
    logic [2:0]      drop_add;
    logic [8:0]      drop_sum;
    logic [1:0]      push_type;
    logic [IRQW-1:0] push_irq;

    // Event qualification and priority selection (NMI > IRQ > decode).
    // Every qualified event that is not the pushed one is a loser and counts
    // as a lost event.
    always_comb begin
        nmi_q     = en & nmi_detect & cap_mask[2];
        irq_q     = en & irq_detect & cap_mask[1];
        dec_q     = en & decode     & cap_mask[0];
        push      = nmi_q | irq_q | dec_q;
        n_qual    = {1'b0, nmi_q} + {1'b0, irq_q} + {1'b0, dec_q};
        losers    = n_qual - {1'b0, push};
        push_type = TYPE_DECODE;
        push_irq  = '0;
        if (nmi_q) begin
            push_type = TYPE_NMI;
        end else if (irq_q) begin
            push_type = TYPE_IRQ;
            push_irq  = irq_num;
        end
    end

    // Buffer control. A push into a full buffer without a simultaneous pop
    // is lost unless wrap is set, in which case it replaces the oldest entry
    // (wr_ptr equals rd_ptr when full, so both pointers advance together).
    always_comb begin
        full      = (count == CW'(DEPTH));
        pop       = rd_valid & rd_ready;
        write     = push & ~clr & (~full | pop | wrap);
        lost_full = push & full & ~pop;
        drop_add  = {1'b0, losers} + {2'b00, lost_full};
        drop_sum  = {1'b0, drop_cnt} + {6'b000000, drop_add};
    end

    // First-word-fall-through read of the head entry
    always_comb begin
        rd_valid   = (count != '0);
        rd_type    = mem_type[rd_ptr];
        rd_pc      = mem_pc[rd_ptr];
        rd_ir      = mem_ir[rd_ptr];
        rd_irq_num = mem_irq[rd_ptr];
        rd_ts      = mem_ts[rd_ptr];
    end

    // Entry array write; contents need no reset since count gates validity
    always_ff @(posedge dbg_clk) begin
        if (write && !dbg_rst) begin
            mem_type[wr_ptr] <= push_type;
            mem_pc[wr_ptr]   <= pc;
            mem_ir[wr_ptr]   <= ir;
            mem_irq[wr_ptr]  <= push_irq;
            mem_ts[wr_ptr]   <= ts;
        end
    end

    // Pointers, occupancy, drop accounting and the free-running timestamp.
    // clr flushes everything except ts and suppresses capture that cycle.
    always_ff @(posedge dbg_clk) begin
        if (dbg_rst) begin
            ts       <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            ts <= ts + TSW'(1);
            if (clr) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                overflow <= 1'b0;
                drop_cnt <= '0;
            end else begin
                if (write) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop || (write && full)) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                if (write && !pop && !full) begin
                    count <= count + CW'(1);
                end else if (pop && !write) begin
                    count <= count - CW'(1);
                end
                if (drop_add != 3'd0) begin
                    overflow <= 1'b1;
                    drop_cnt <= (drop_sum > 9'd255) ? 8'd255 : drop_sum[7:0];
                end
            end
        end
    end

endmodule
